// File: rtl/conv2d_stream_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and constants for the conv2d_stream convolver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Product register stage followed by the sum register stage
    localparam int PIPE_DEPTH = 2;

    function automatic int acc_width(input int data_w, input int wgt_w, input int k);
        return data_w + wgt_w + $clog2(k * k) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_stream_if.sv
// ============================================================================
// Module   : conv2d_stream_if
// Brief    : Control, kernel, activation and result signals of conv2d_stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv2d_stream_if
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8
);
    localparam int ACC_W = acc_width(DATA_W, WGT_W, K);

    logic                       start;
    logic [K*K*WGT_W-1:0]       weights;
    logic                       act_valid;
    logic [DATA_W-1:0]          activation;
    logic signed [ACC_W-1:0]    P_out;
    logic                       out_valid;
    logic                       finish;
    logic                       busy;

    modport master (
        output start, weights, act_valid, activation,
        input  P_out, out_valid, finish, busy
    );

    modport slave (
        input  start, weights, act_valid, activation,
        output P_out, out_valid, finish, busy
    );

endinterface

`default_nettype wire

// File: rtl/conv2d_stream_line_buffer.sv
// ============================================================================
// Module   : conv_line_buffer
// Brief    : Enable-gated shift register delaying one image row segment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5
) (
    input  wire                 clock,
    input  wire                 shift_en,
    input  wire  [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_sr
            logic [DATA_W-1:0] r_sr [DEPTH];

            always_ff @(posedge clock) begin
                if (shift_en) begin
                    r_sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign dout = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/conv2d_stream.sv
// ============================================================================
// Module   : conv2d_stream
// Brief    : Streaming KxK 2-D convolver with line buffers and 2-stage MAC.
//            Define CONV_RELU_EN to clamp negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2d_stream
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8
) (
    input  wire             clock,
    input  wire             reset,
    conv2d_stream_if.slave  bus
);

    localparam int ACC_W    = acc_width(DATA_W, WGT_W, K);
    localparam int NTAP     = K * K;
    localparam int LB_DEPTH = IMG_W - K;
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic signed [WGT_W-1:0]    r_wgt [NTAP];
    logic [DATA_W-1:0]          r_win [K][K];
    logic [DATA_W-1:0]          w_lb_out [K-1];
    logic signed [ACC_W-1:0]    r_prod [NTAP];
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    r_p_out;
    logic                       r_win_vld;
    logic                       r_win_last;
    logic [PIPE_DEPTH-1:0]      r_vld_sr;
    logic [PIPE_DEPTH-1:0]      r_last_sr;
    logic                       w_accept;
    logic                       w_start;
    logic                       w_col_end;
    logic                       w_row_end;
    logic                       w_win_full;

    assign w_accept   = (r_state == S_RUN) && bus.act_valid;
    assign w_start    = (r_state == S_IDLE) && bus.start;
    assign w_col_end  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_end  = (r_row == ROW_W'(IMG_H - 1));
    assign w_win_full = (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && w_col_end && w_row_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_last_sr[PIPE_DEPTH-1]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Position of the pixel being accepted this cycle
    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_start) begin
            for (int i = 0; i < NTAP; i++) begin
                r_wgt[i] <= bus.weights[i*WGT_W +: WGT_W];
            end
        end
    end

    // Row K-1 takes the live pixel; older rows are fed from the line buffers
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            for (int r = 0; r < K-1; r++) begin
                r_win[r][K-1] <= w_lb_out[r];
            end
            r_win[K-1][K-1] <= bus.activation;
        end
    end

    generate
        for (genvar g = 0; g < K-1; g++) begin : g_lb
            conv_line_buffer #(
                .DATA_W (DATA_W),
                .DEPTH  (LB_DEPTH)
            ) u_lb (
                .clock    (clock),
                .shift_en (w_accept),
                .din      (r_win[g+1][0]),
                .dout     (w_lb_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
            r_vld_sr   <= '0;
            r_last_sr  <= '0;
        end else begin
            r_win_vld  <= w_accept && w_win_full;
            r_win_last <= w_accept && w_col_end && w_row_end;
            r_vld_sr   <= {r_vld_sr[PIPE_DEPTH-2:0], r_win_vld};
            r_last_sr  <= {r_last_sr[PIPE_DEPTH-2:0], r_win_last};
        end
    end

    // Stage 1: activations zero-extended, weights sign-extended
    always_ff @(posedge clock) begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                r_prod[r*K+c] <= $signed(ACC_W'(r_win[r][c])) * ACC_W'(r_wgt[r*K+c]);
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NTAP; i++) begin
            w_sum = w_sum + r_prod[i];
        end
    end

    // Stage 2: result register holds between valid windows
    always_ff @(posedge clock) begin
        if (reset) begin
            r_p_out <= '0;
        end else if (r_vld_sr[0]) begin
`ifdef CONV_RELU_EN
            r_p_out <= w_sum[ACC_W-1] ? '0 : w_sum;
`else
            r_p_out <= w_sum;
`endif
        end
    end

    assign bus.P_out     = r_p_out;
    assign bus.out_valid = r_vld_sr[PIPE_DEPTH-1];
    assign bus.finish    = r_last_sr[PIPE_DEPTH-1];
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv2d_stream.sv
// ============================================================================
// Module   : tb_conv2d_stream
// Brief    : Directed self-checking bench for conv2d_stream (K=3, 8x8 image).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv2d_stream;

    localparam int K      = 3;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int DATA_W = 8;
    localparam int WGT_W  = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int OW     = IMG_W - K + 1;
    localparam int NOUT   = OW * (IMG_H - K + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv2d_stream_if #(.K(K), .DATA_W(DATA_W), .WGT_W(WGT_W)) bus ();

    conv2d_stream #(
        .K      (K),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W),
        .WGT_W  (WGT_W)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    longint out_q[$];
    int     out_cyc_q[$];
    int     fin_cnt    = 0;
    int     fin_idx    = 0;
    int     fin_cyc    = 0;
    logic   fin_vld    = 1'b0;
    logic   fin_prev   = 1'b0;
    logic   busy_after = 1'b1;

    int                     acc_cyc [NPIX];
    int                     img     [NPIX];
    logic [K*K*WGT_W-1:0]   wvec;

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector, sampled on the falling edge
    always @(negedge clk) begin
        if (fin_prev) busy_after = bus.busy;
        fin_prev = bus.finish;
        if (bus.out_valid) begin
            out_q.push_back(longint'(bus.P_out));
            out_cyc_q.push_back(cyc);
        end
        if (bus.finish) begin
            fin_cnt = fin_cnt + 1;
            fin_idx = out_q.size();
            fin_cyc = cyc;
            fin_vld = bus.out_valid;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint golden(input int p);
        int     row;
        int     col;
        longint s;
        row = p / IMG_W;
        col = p % IMG_W;
        s   = 0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                s += longint'($signed(wvec[(r*K+c)*WGT_W +: WGT_W])) *
                     longint'(img[(row-K+1+r)*IMG_W + (col-K+1+c)]);
            end
        end
        return s;
    endfunction

    task automatic do_start(input logic [K*K*WGT_W-1:0] w);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.weights = w;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int gap_max, input int start_at);
        for (int p = 0; p < npix; p++) begin
            if (gap_max > 0 && p > 0) begin
                int n;
                n = $urandom_range(gap_max, 1);
                bus.act_valid = 1'b0;
                repeat (n) @(negedge clk);
            end
            bus.act_valid  = 1'b1;
            bus.activation = DATA_W'(img[p]);
            if (p == start_at) begin
                bus.start   = 1'b1;
                bus.weights = '0;
            end else begin
                bus.start = 1'b0;
            end
            acc_cyc[p] = cyc + 1;
            @(negedge clk);
        end
        bus.act_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic wait_finish(input int fb);
        for (int i = 0; i < 40 && fin_cnt == fb; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int ob, input int fb,
                               input bit use_const, input longint cval);
        int n;
        n = out_q.size() - ob;
        check({tag, "_count"}, n, NOUT);
        for (int k = 0; k < NOUT && k < n; k++) begin
            int p;
            p = (K-1 + k/OW)*IMG_W + (K-1) + k%OW;
            check($sformatf("%s_val%0d", tag, k), out_q[ob+k], use_const ? cval : golden(p));
            check($sformatf("%s_lat%0d", tag, k), out_cyc_q[ob+k] - acc_cyc[p], 2);
        end
        check({tag, "_fin_seen"},  fin_cnt - fb, 1);
        check({tag, "_fin_idx"},   fin_idx - ob, NOUT);
        check({tag, "_fin_valid"}, fin_vld, 1);
        check({tag, "_fin_lat"},   fin_cyc - acc_cyc[NPIX-1], 2);
        check({tag, "_busy_fall"}, busy_after, 0);
    endtask

    initial begin
        int ob;
        int fb;
        longint neg_exp;

        bus.start      = 1'b0;
        bus.weights    = '0;
        bus.act_valid  = 1'b0;
        bus.activation = '0;

        repeat (3) @(negedge clk);
        check("rst_pout",   bus.P_out, 0);
        check("rst_valid",  bus.out_valid, 0);
        check("rst_finish", bus.finish, 0);
        check("rst_busy",   bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // All ones: every window sums to 9
        for (int p = 0; p < NPIX; p++) img[p] = 1;
        wvec = {9{8'h01}};
        ob = out_q.size(); fb = fin_cnt;
        do_start(wvec);
        check("ones_busy_run", bus.busy, 1);
        send_frame(NPIX, 0, -1);
        wait_finish(fb);
        check_frame("ones", ob, fb, 1'b1, 9);

        // Ramp weights 0..8, activations i%5; first window hand-computed as 74
        for (int p = 0; p < NPIX; p++) img[p] = p % 5;
        wvec = 72'h08_07_06_05_04_03_02_01_00;
        ob = out_q.size(); fb = fin_cnt;
        do_start(wvec);
        send_frame(NPIX, 0, -1);
        wait_finish(fb);
        check_frame("ramp", ob, fb, 1'b0, 0);
        check("ramp_first", (out_q.size() > ob) ? out_q[ob] : -1, 74);
        check("ramp_first_lat", (out_cyc_q.size() > ob) ? out_cyc_q[ob] - acc_cyc[18] : -1, 2);
        repeat (5) @(negedge clk);
        check("ramp_hold", bus.P_out, golden(NPIX-1));

        // Same stream with random stalls between beats
        ob = out_q.size(); fb = fin_cnt;
        do_start(wvec);
        send_frame(NPIX, 5, -1);
        wait_finish(fb);
        check_frame("stall", ob, fb, 1'b0, 0);

        // Negative weights: -90 raw, clamped to 0 with ReLU
`ifdef CONV_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -90;
`endif
        for (int p = 0; p < NPIX; p++) img[p] = 10;
        wvec = {9{8'hFF}};
        ob = out_q.size(); fb = fin_cnt;
        do_start(wvec);
        send_frame(NPIX, 0, -1);
        wait_finish(fb);
        check_frame("neg", ob, fb, 1'b1, neg_exp);

        // Reset after 30 pixels aborts the frame
        for (int p = 0; p < NPIX; p++) img[p] = 1;
        wvec = {9{8'h01}};
        do_start(wvec);
        send_frame(30, 0, -1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_pout",   bus.P_out, 0);
        check("abort_valid",  bus.out_valid, 0);
        check("abort_finish", bus.finish, 0);
        check("abort_busy",   bus.busy, 0);
        rst = 1'b0;
        ob = out_q.size(); fb = fin_cnt;
        repeat (12) @(negedge clk);
        check("abort_no_out", out_q.size() - ob, 0);
        check("abort_no_fin", fin_cnt - fb, 0);
        check("abort_idle",   bus.busy, 0);
        ob = out_q.size(); fb = fin_cnt;
        do_start(wvec);
        send_frame(NPIX, 0, -1);
        wait_finish(fb);
        check_frame("after_rst", ob, fb, 1'b1, 9);

        // start with zero weights mid-frame must be ignored
        ob = out_q.size(); fb = fin_cnt;
        do_start(wvec);
        send_frame(NPIX, 0, 20);
        wait_finish(fb);
        check_frame("midstart", ob, fb, 1'b1, 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
